sc_usequencer: RTL and testbench

Microprogram sequencer for the ARC-style microcoded datapath. It sits directly downstream of the instruction register and consumes the OP/OP2/OP3/BIT13 fields. It also takes the PSR flags and the COND/JUMP ADDR fields of the current microword. Each cycle it produces the next control-store address (CSAI), so it effectively replaces the microstore's program counter. It also supports memory wait stalls and counts decoded instructions.

---
 rtl/sc_usequencer.sv | 135 +++++++++++++
 tb/tb_sc_usequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_usequencer.sv
// Microprogram sequencer: computes the next control-store address each cycle,
// decodes instruction fields into dispatch targets, stalls on memory wait and
// counts decode dispatches.
//
// Handshake: sequencing has no valid/ready pair. SC_uSeq_Wait_InHigh works as an
// inverted "ready": an address loads on a rising edge only when wait is low (and
// the FSM is past BOOT). While wait is high, CSAI, the counter and Decode_Out
// hold their "no load" behaviour.
module sc_usequencer #(
   parameter int                   ADDRWIDTH  = 11,
   parameter logic [ADDRWIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                 SC_uSeq_CLOCK_50,
   input  logic                 SC_uSeq_Reset_InLow,
   input  logic                 SC_uSeq_Wait_InHigh,
   input  logic [2:0]           SC_uSeq_COND,
   input  logic [ADDRWIDTH-1:0] SC_uSeq_JumpAddr,
   input  logic [1:0]           SC_uSeq_OP,
   input  logic [2:0]           SC_uSeq_OP2,
   input  logic [5:0]           SC_uSeq_OP3,
   input  logic                 SC_uSeq_BIT13,
   input  logic                 SC_uSeq_N,
   input  logic                 SC_uSeq_Z,
   input  logic                 SC_uSeq_V,
   input  logic                 SC_uSeq_C,
   output logic [ADDRWIDTH-1:0] SC_uSeq_CSAI,
   output logic                 SC_uSeq_Decode_Out,
   output logic                 SC_uSeq_Stalled,
   output logic [15:0]          SC_uSeq_InstrCount,
   output logic [1:0]           SC_uSeq_State
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   load;
   logic                   take_jump;
   logic                   is_decode;
   logic [5:0]             dec_field;
   logic [ADDRWIDTH-1:0]   decode_addr;
   logic [ADDRWIDTH-1:0]   seq_addr;
   logic [ADDRWIDTH-1:0]   next_addr;

   assign is_decode = (SC_uSeq_COND == 3'b111);
   assign seq_addr  = SC_uSeq_CSAI + {{(ADDRWIDTH-1){1'b0}}, 1'b1};

   // Dispatch target: format-specific field selection from the IR.
   always_comb begin
      dec_field = 6'b000000;
      case (SC_uSeq_OP)
         2'b00:   dec_field = {SC_uSeq_OP2, 3'b000};
         2'b01:   dec_field = 6'b000000;
         default: dec_field = SC_uSeq_OP3;
      endcase
      decode_addr = {1'b1, SC_uSeq_OP, dec_field, 2'b00};
   end

   // Branch condition evaluation and next-address mux.
   always_comb begin
      take_jump = 1'b0;
      case (SC_uSeq_COND)
         3'b001:  take_jump = SC_uSeq_N;
         3'b010:  take_jump = SC_uSeq_Z;
         3'b011:  take_jump = SC_uSeq_V;
         3'b100:  take_jump = SC_uSeq_C;
         3'b101:  take_jump = SC_uSeq_BIT13;
         3'b110:  take_jump = 1'b1;
         default: take_jump = 1'b0;
      endcase
      if (is_decode)
         next_addr = decode_addr;
      else if (take_jump)
         next_addr = SC_uSeq_JumpAddr;
      else
         next_addr = seq_addr;
   end

   // FSM state register.
   always_ff @(posedge SC_uSeq_CLOCK_50 or negedge SC_uSeq_Reset_InLow) begin
      if (!SC_uSeq_Reset_InLow)
         state <= ST_BOOT;
      else
         state <= next_state;
   end

   // FSM next state and load strobe; BOOT ignores wait and COND.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         ST_BOOT: begin
            next_state = ST_RUN;
         end
         ST_RUN: begin
            if (SC_uSeq_Wait_InHigh)
               next_state = ST_STALL;
            else
               load = 1'b1;
         end
         ST_STALL: begin
            if (!SC_uSeq_Wait_InHigh) begin
               load       = 1'b1;
               next_state = ST_RUN;
            end
         end
         default: begin
            next_state = ST_BOOT;
         end
      endcase
   end

   // Address, decode flag and dispatch counter; a held decode never counts.
   always_ff @(posedge SC_uSeq_CLOCK_50 or negedge SC_uSeq_Reset_InLow) begin
      if (!SC_uSeq_Reset_InLow) begin
         SC_uSeq_CSAI       <= RESET_ADDR;
         SC_uSeq_Decode_Out <= 1'b0;
         SC_uSeq_InstrCount <= 16'h0000;
      end else begin
         SC_uSeq_Decode_Out <= load & is_decode;
         if (load)
            SC_uSeq_CSAI <= next_addr;
         if (load && is_decode)
            SC_uSeq_InstrCount <= SC_uSeq_InstrCount + 16'h0001;
      end
   end

   assign SC_uSeq_Stalled = (state == ST_STALL);
   assign SC_uSeq_State   = state;

endmodule

// File: tb/tb_sc_usequencer.sv
// Bench for sc_usequencer: directed vector table, stall/wrap/reset sequences and
// random stimulus compared against an address-level reference model.
module tb_sc_usequencer;

   logic        clk;
   logic        rst_n;
   logic        wait_in;
   logic [2:0]  cond;
   logic [10:0] jump;
   logic [1:0]  op;
   logic [2:0]  op2;
   logic [5:0]  op3;
   logic        bit13;
   logic        n, z, v, c;
   logic [10:0] csai;
   logic        dec_out;
   logic        stalled;
   logic [15:0] icount;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_csai;
   int          m_count;
   bit          m_dec;
   bit          m_stalled;
   bit          m_boot;
   logic [10:0] exp_q[$];

   sc_usequencer dut (
      .SC_uSeq_CLOCK_50   (clk),
      .SC_uSeq_Reset_InLow(rst_n),
      .SC_uSeq_Wait_InHigh(wait_in),
      .SC_uSeq_COND       (cond),
      .SC_uSeq_JumpAddr   (jump),
      .SC_uSeq_OP         (op),
      .SC_uSeq_OP2        (op2),
      .SC_uSeq_OP3        (op3),
      .SC_uSeq_BIT13      (bit13),
      .SC_uSeq_N          (n),
      .SC_uSeq_Z          (z),
      .SC_uSeq_V          (v),
      .SC_uSeq_C          (c),
      .SC_uSeq_CSAI       (csai),
      .SC_uSeq_Decode_Out (dec_out),
      .SC_uSeq_Stalled    (stalled),
      .SC_uSeq_InstrCount (icount),
      .SC_uSeq_State      (state_dbg)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  cond;
      logic [10:0] jump;
      logic [1:0]  op;
      logic [2:0]  op2;
      logic [5:0]  op3;
      logic        bit13;
      logic [3:0]  nzvc;
      logic [10:0] exp_csai;
      logic        exp_dec;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(input logic [2:0] c_v, input logic [10:0] j_v,
                               input logic [1:0] op_v, input logic [2:0] op2_v,
                               input logic [5:0] op3_v, input logic b_v,
                               input logic [3:0] f_v, input logic [10:0] e_v,
                               input logic d_v);
      vec_t r;
      r.cond = c_v; r.jump = j_v; r.op = op_v; r.op2 = op2_v; r.op3 = op3_v;
      r.bit13 = b_v; r.nzvc = f_v; r.exp_csai = e_v; r.exp_dec = d_v;
      return r;
   endfunction

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // model: dispatch target straight from the instruction-format rules
   function automatic int model_decode(input int op_v, input int op2_v, input int op3_v);
      case (op_v)
         0:       return 1024 + op2_v * 32;
         1:       return 1024 + 256;
         2:       return 1024 + 512 + op3_v * 4;
         default: return 1024 + 768 + op3_v * 4;
      endcase
   endfunction

   function automatic void model_reset();
      m_csai = 0; m_count = 0; m_dec = 0; m_stalled = 0; m_boot = 1;
      exp_q.delete();
   endfunction

   function automatic void model_edge();
      int target;
      bit jmp;
      if (m_boot) begin
         m_boot = 0; m_csai = 0; m_dec = 0; m_stalled = 0;
      end else if (wait_in) begin
         m_dec = 0; m_stalled = 1;
      end else begin
         jmp = (cond == 1 && n) || (cond == 2 && z) || (cond == 3 && v) ||
               (cond == 4 && c) || (cond == 5 && bit13) || (cond == 6);
         if (cond == 7)      target = model_decode(op, op2, op3);
         else if (jmp)       target = jump;
         else                target = m_csai + 1;
         m_csai    = target % 2048;
         m_dec     = (cond == 7);
         m_count   = m_dec ? (m_count + 1) % 65536 : m_count;
         m_stalled = 0;
      end
      exp_q.push_back(11'(m_csai));
   endfunction

   // driver: called at a falling edge, returns at the next falling edge
   task automatic step(input logic [2:0] c_v, input logic [10:0] j_v,
                       input logic [1:0] op_v, input logic [2:0] op2_v,
                       input logic [5:0] op3_v, input logic b_v,
                       input logic [3:0] f_v, input logic w_v, input bit do_check);
      logic [10:0] e;
      cond = c_v; jump = j_v; op = op_v; op2 = op2_v; op3 = op3_v;
      bit13 = b_v; {n, z, v, c} = f_v; wait_in = w_v;
      @(posedge clk);
      model_edge();
      #1;
      e = exp_q.pop_front();
      if (do_check) begin
         chk("csai", int'(csai), int'(e));
         chk("decode_out", int'(dec_out), int'(m_dec));
         chk("stalled", int'(stalled), int'(m_stalled));
         chk("instr_count", int'(icount), m_count);
      end
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_csai"}, int'(csai), 0);
      chk({tag, "_decode_out"}, int'(dec_out), 0);
      chk({tag, "_stalled"}, int'(stalled), 0);
      chk({tag, "_instr_count"}, int'(icount), 0);
   endtask

   initial begin
      rst_n = 1'b0; wait_in = 1'b0; cond = '0; jump = '0; op = '0; op2 = '0;
      op3 = '0; bit13 = 1'b0; {n, z, v, c} = 4'b0000;
      model_reset();

      tbl[0]  = mk(3'd0, 11'h000, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'd1, 1'b0);
      tbl[1]  = mk(3'd0, 11'h000, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'd2, 1'b0);
      tbl[2]  = mk(3'd0, 11'h7AA, 2'd0, 3'd0, 6'd0, 1'b1, 4'b1111, 11'd3, 1'b0);
      tbl[3]  = mk(3'd1, 11'h155, 2'd0, 3'd0, 6'd0, 1'b0, 4'b1000, 11'h155, 1'b0);
      tbl[4]  = mk(3'd1, 11'h155, 2'd0, 3'd0, 6'd0, 1'b1, 4'b0111, 11'h156, 1'b0);
      tbl[5]  = mk(3'd2, 11'h2AA, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0100, 11'h2AA, 1'b0);
      tbl[6]  = mk(3'd2, 11'h2AA, 2'd0, 3'd0, 6'd0, 1'b1, 4'b1011, 11'h2AB, 1'b0);
      tbl[7]  = mk(3'd3, 11'h010, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0010, 11'h010, 1'b0);
      tbl[8]  = mk(3'd3, 11'h7FF, 2'd0, 3'd0, 6'd0, 1'b1, 4'b1101, 11'h011, 1'b0);
      tbl[9]  = mk(3'd4, 11'h300, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0001, 11'h300, 1'b0);
      tbl[10] = mk(3'd4, 11'h300, 2'd0, 3'd0, 6'd0, 1'b1, 4'b1110, 11'h301, 1'b0);
      tbl[11] = mk(3'd5, 11'h123, 2'd0, 3'd0, 6'd0, 1'b1, 4'b0000, 11'h123, 1'b0);
      tbl[12] = mk(3'd5, 11'h123, 2'd0, 3'd0, 6'd0, 1'b0, 4'b1111, 11'h124, 1'b0);
      tbl[13] = mk(3'd6, 11'h7FF, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'h7FF, 1'b0);
      tbl[14] = mk(3'd0, 11'h456, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'h000, 1'b0);
      tbl[15] = mk(3'd6, 11'h000, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'h000, 1'b0);
      tbl[16] = mk(3'd6, 11'h000, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 11'h000, 1'b0);
      tbl[17] = mk(3'd7, 11'h3FF, 2'd2, 3'd2, 6'b010000, 1'b0, 4'b1111, 11'd1600, 1'b1);
      tbl[18] = mk(3'd7, 11'h3FF, 2'd0, 3'b100, 6'b100111, 1'b1, 4'b0000, 11'd1152, 1'b1);
      tbl[19] = mk(3'd7, 11'h3FF, 2'd1, 3'b111, 6'b111111, 1'b1, 4'b1111, 11'd1280, 1'b1);
      tbl[20] = mk(3'd7, 11'h3FF, 2'd3, 3'd0, 6'b000000, 1'b0, 4'b0000, 11'd1792, 1'b1);
      tbl[21] = mk(3'd7, 11'h3FF, 2'd2, 3'd0, 6'b000000, 1'b0, 4'b0000, 11'd1536, 1'b1);
      tbl[22] = mk(3'd0, 11'h3FF, 2'd2, 3'd0, 6'b000000, 1'b0, 4'b0000, 11'd1537, 1'b0);

      // reset state
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // BOOT edge ignores wait and COND
      step(3'd6, 11'h555, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b1, 1);
      chk("boot_csai", int'(csai), 0);

      // directed vector table
      for (int i = 0; i < 23; i++) begin
         step(tbl[i].cond, tbl[i].jump, tbl[i].op, tbl[i].op2, tbl[i].op3,
              tbl[i].bit13, tbl[i].nzvc, 1'b0, 1);
         chk($sformatf("tbl%0d_csai", i), int'(csai), int'(tbl[i].exp_csai));
         chk($sformatf("tbl%0d_dec", i), int'(dec_out), int'(tbl[i].exp_dec));
      end
      chk("tbl_count", int'(icount), 5);

      // wait stall over a pending decode (call)
      for (int i = 0; i < 3; i++) begin
         step(3'd7, 11'h0, 2'd1, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b1, 1);
         chk("stall_hold_csai", int'(csai), 1537);
         chk("stall_flag", int'(stalled), 1);
         chk("stall_count", int'(icount), 5);
         chk("stall_dec", int'(dec_out), 0);
      end
      step(3'd7, 11'h0, 2'd1, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1);
      chk("unstall_csai", int'(csai), 1280);
      chk("unstall_count", int'(icount), 6);
      chk("unstall_dec", int'(dec_out), 1);
      chk("unstall_flag", int'(stalled), 0);
      step(3'd0, 11'h0, 2'd1, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1);
      chk("post_decode_dec", int'(dec_out), 0);

      // randomized stimulus against the model
      for (int i = 0; i < 400; i++) begin
         step(3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1);
      end

      // counter wrap: bulk decodes up to 0xFFFF, then one more
      while (m_count != 65535)
         step(3'd7, 11'h0, 2'd2, 3'd0, 6'($urandom_range(0, 63)), 1'b0, 4'b0000, 1'b0, 0);
      chk("count_ffff", int'(icount), 65535);
      step(3'd7, 11'h0, 2'd3, 3'd0, 6'd5, 1'b0, 4'b0000, 1'b0, 1);
      chk("count_wrap", int'(icount), 0);

      // async reset between edges during a stall
      step(3'd7, 11'h0, 2'd0, 3'd1, 6'd0, 1'b0, 4'b0000, 1'b1, 1);
      step(3'd7, 11'h0, 2'd0, 3'd1, 6'd0, 1'b0, 4'b0000, 1'b1, 1);
      chk("pre_reset_stalled", int'(stalled), 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(3'd6, 11'h321, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1);
      chk("reboot_csai", int'(csai), 0);
      step(3'd0, 11'h0, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1);
      chk("rerun_csai1", int'(csai), 1);
      step(3'd0, 11'h0, 2'd0, 3'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1);
      chk("rerun_csai2", int'(csai), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
